// File: rtl/chunked_serial_adder.sv
// Sequential adder: sums two WIDTH-bit operands CHUNK bits per clock with a start/busy/done handshake.
// Optional subtract mode (sub port, a - b - cin) is built when SERIAL_ADDER_SUB_EN is defined.
module chunked_serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;
    logic accept_c, finish_c;

    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] b_in_c;
    logic             cin_in_c;
    logic [CHUNK:0]   add_c;
    logic [WIDTH-1:0] res_c;
    logic             msb_cin_c;

    // Operand conditioning: subtraction is a + ~b + ~cin
`ifdef SERIAL_ADDER_SUB_EN
    assign b_in_c   = sub ? ~b : b;
    assign cin_in_c = cin ^ sub;
`else
    assign b_in_c   = b;
    assign cin_in_c = cin;
`endif

    assign add_c = (CHUNK+1)'(a_q[CHUNK-1:0]) + (CHUNK+1)'(b_q[CHUNK-1:0]) + (CHUNK+1)'(carry_q);
    assign res_c = (res_q >> CHUNK) | (WIDTH'(add_c[CHUNK-1:0]) << (WIDTH - CHUNK));
    // Carry into the MSB recovered from the top bit of the final chunk
    assign msb_cin_c = add_c[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        finish_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    finish_c = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept_c = 1'b1;
                    state_d  = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= finish_c;
            if (accept_c) begin
                a_q     <= a;
                b_q     <= b_in_c;
                carry_q <= cin_in_c;
                cnt_q   <= '0;
                busy    <= 1'b1;
            end else if (state_q == RUN) begin
                a_q     <= a_q >> CHUNK;
                b_q     <= b_q >> CHUNK;
                res_q   <= res_c;
                carry_q <= add_c[CHUNK];
                cnt_q   <= cnt_q + CW'(1);
                if (finish_c) begin
                    busy <= 1'b0;
                    sum  <= res_c;
                    cout <= add_c[CHUNK];
                    ovf  <= msb_cin_c ^ add_c[CHUNK];
                end
            end
        end
    end

endmodule
